dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the dual-port data memory (one write port, one registered read port with write-through) between two requesters: port 0 = CPU load/store unit, port 1 = DMA/debug master.
- Read and write ports are arbitrated independently, so a write from one requester and a read from the other can both be granted in the same cycle.
- Sits between the requesters and the data memory instance; purely a controller, no storage of memory contents.

Parameters:
- A_WIDTH, 8, memory address width.
- D_WIDTH, 32, memory data width.
- MAX_WAIT, 4, used only with the optional feature: consecutive lost arbitrations on port 1 before it is forced.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0, req1  input  1 each  request valid, held until granted.
- we0, we1  input  1 each  1 = write, 0 = read.
- addr0, addr1  input  A_WIDTH each  request address.
- wdata0, wdata1  input  D_WIDTH each  write data.
- gnt0, gnt1  output  1 each  request accepted this cycle (combinational).
- rvalid0, rvalid1  output  1 each  read data valid for that port (registered).
- rdata  output  D_WIDTH  read data, shared by both ports, qualified by rvalid0/rvalid1.
- mem_we  output  1  to memory we.
- mem_w_addr  output  A_WIDTH  to memory w_addr.
- mem_w_data  output  D_WIDTH  to memory w_data.
- mem_re  output  1  to memory re.
- mem_r_addr  output  A_WIDTH  to memory r_addr.
- mem_r_data  input  D_WIDTH  from memory r_data.

Behaviour:
- Request classes:
  - Write requesters: {reqN && weN}.
  - Read requesters: {reqN && !weN}.
  - Each class has its own arbiter.
- Round-robin state:
  - One priority bit per class: wr_ptr and rd_ptr. The pointer names the port favoured on a tie.
  - If a single requester is present in a class, it wins regardless of its pointer.
  - If both are present, the favoured port wins, and the pointer flips to the other port at the clock edge.
  - A pointer changes only when a tie occurs.
- Grants:
  - gntN = 1 when port N wins its class. At most one write grant and one read grant per cycle.
  - A single port never receives both a read and a write in one cycle, because weN selects its class.
- Memory drive (combinational):
  - mem_we = any write grant. mem_w_addr and mem_w_data are muxed from the write winner.
  - mem_re = any read grant. mem_r_addr is muxed from the read winner.
  - When no grant is active, the address and data outputs are 0.
- Read return:
  - Latency is exactly 1 cycle.
  - A registered 1-bit tag records the read winner. rvalidN is asserted for one cycle in the cycle after the read grant.
  - rdata = mem_r_data, passed through.
- Same-address read and write in one cycle: the memory write-through returns the new data. The arbiter adds no hazard logic.
- Back-to-back reads: each cycle may issue a new read. Successive rvalid pulses track successive grants.
- Reset, asserted at any time:
  - gnt0/gnt1, mem_we and mem_re are forced to 0 while rst = 1.
  - rvalid0/rvalid1 go to 0 immediately.
  - wr_ptr and rd_ptr go to 0 (port 0 favoured).
  - An in-flight read is dropped, and no rvalid follows reset release.
- First cycle after reset release: normal arbitration.

Optional Feature:
- Macro: DMEM_ARB_PRIO_EN.
- Defined:
  - Port 0 has fixed priority in both classes.
  - Per-class saturating counter (width clog2(MAX_WAIT+1)) counts consecutive cycles where port 1 requests in that class and loses.
  - When the counter equals MAX_WAIT, port 1 wins the next tie, and the counter clears.
  - The counter also clears whenever port 1 is granted in that class or drops its request.
  - Counters reset to 0. wr_ptr and rd_ptr are unused.
- Undefined: pure round-robin as above. No counters are present.

Test Plan:
- Reset, then req0 read addr 0x10 (memory preloaded 0x10 = 0xDEADBEEF) -> gnt0 = 1 same cycle, mem_re = 1, mem_r_addr = 0x10; next cycle rvalid0 = 1, rdata = 0xDEADBEEF, rvalid1 = 0.
- Port 0 writes 0x20 = 0x12345678 while port 1 reads 0x20 in the same cycle -> gnt0 = gnt1 = 1, mem_we = mem_re = 1; next cycle rvalid1 = 1, rdata = 0x12345678 (write-through).
- Both ports read continuously for 4 cycles after reset -> grants alternate 0, 1, 0, 1; rvalid0/rvalid1 alternate with 1-cycle lag; rd_ptr ends at 0.
- Both ports write every cycle, and port 1 gets a solo write in between -> wr_ptr does not change on the solo write; the tie order resumes correctly.
- Port 1 read granted, rst pulsed before the next edge -> rvalid1 = 0 throughout and after release; pointers = 0; the first post-reset tie goes to port 0.
- With DMEM_ARB_PRIO_EN and MAX_WAIT = 4, both ports read continuously -> port 0 granted 4 consecutive cycles, port 1 granted on the 5th, then the pattern repeats.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for a dual-port data memory: independent read and write arbiters.
// Optional macro DMEM_ARB_PRIO_EN: port 0 fixed priority with MAX_WAIT anti-starvation for port 1.
module dmem_port_arbiter #(
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned D_WIDTH  = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic               i_we0,
  input  logic               i_we1,
  input  logic [A_WIDTH-1:0] i_addr0,
  input  logic [A_WIDTH-1:0] i_addr1,
  input  logic [D_WIDTH-1:0] i_wdata0,
  input  logic [D_WIDTH-1:0] i_wdata1,
  output logic               o_gnt0,
  output logic               o_gnt1,
  output logic               o_rvalid0,
  output logic               o_rvalid1,
  output logic [D_WIDTH-1:0] o_rdata,
  output logic               o_mem_we,
  output logic [A_WIDTH-1:0] o_mem_w_addr,
  output logic [D_WIDTH-1:0] o_mem_w_data,
  output logic               o_mem_re,
  output logic [A_WIDTH-1:0] o_mem_r_addr,
  input  logic [D_WIDTH-1:0] i_mem_r_data
);

  logic w_wr_req0, w_wr_req1, w_rd_req0, w_rd_req1;
  logic w_wr_win0, w_wr_win1, w_rd_win0, w_rd_win1;
  logic w_wr_pick1, w_rd_pick1;
  logic r_rvalid, r_rtag;

  // Requests are masked while reset is held so nothing is granted or issued.
  assign w_wr_req0 = i_req0 & i_we0 & ~i_rst;
  assign w_wr_req1 = i_req1 & i_we1 & ~i_rst;
  assign w_rd_req0 = i_req0 & ~i_we0 & ~i_rst;
  assign w_rd_req1 = i_req1 & ~i_we1 & ~i_rst;

`ifdef DMEM_ARB_PRIO_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;

  assign w_wr_pick1 = (r_wr_cnt == CNT_W'(MAX_WAIT));
  assign w_rd_pick1 = (r_rd_cnt == CNT_W'(MAX_WAIT));

  // Count consecutive losses of port 1; any grant or dropped request clears.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_req1 && !w_wr_win1) begin
        r_wr_cnt <= w_wr_pick1 ? r_wr_cnt : r_wr_cnt + 1'b1;
      end else begin
        r_wr_cnt <= '0;
      end
      if (w_rd_req1 && !w_rd_win1) begin
        r_rd_cnt <= w_rd_pick1 ? r_rd_cnt : r_rd_cnt + 1'b1;
      end else begin
        r_rd_cnt <= '0;
      end
    end
  end
`else
  logic r_wr_ptr, r_rd_ptr;

  assign w_wr_pick1 = r_wr_ptr;
  assign w_rd_pick1 = r_rd_ptr;

  // Pointer moves only on a tie, handing the next tie to the loser.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_wr_req0 && w_wr_req1) r_wr_ptr <= ~r_wr_ptr;
      if (w_rd_req0 && w_rd_req1) r_rd_ptr <= ~r_rd_ptr;
    end
  end
`endif

  assign w_wr_win1 = w_wr_req1 & (~w_wr_req0 | w_wr_pick1);
  assign w_wr_win0 = w_wr_req0 & ~w_wr_win1;
  assign w_rd_win1 = w_rd_req1 & (~w_rd_req0 | w_rd_pick1);
  assign w_rd_win0 = w_rd_req0 & ~w_rd_win1;

  always_comb begin
    o_gnt0       = w_wr_win0 | w_rd_win0;
    o_gnt1       = w_wr_win1 | w_rd_win1;
    o_mem_we     = w_wr_win0 | w_wr_win1;
    o_mem_re     = w_rd_win0 | w_rd_win1;
    o_mem_w_addr = '0;
    o_mem_w_data = '0;
    o_mem_r_addr = '0;
    if (w_wr_win0) begin
      o_mem_w_addr = i_addr0;
      o_mem_w_data = i_wdata0;
    end else if (w_wr_win1) begin
      o_mem_w_addr = i_addr1;
      o_mem_w_data = i_wdata1;
    end
    if (w_rd_win0) begin
      o_mem_r_addr = i_addr0;
    end else if (w_rd_win1) begin
      o_mem_r_addr = i_addr1;
    end
  end

  // The tag remembers which port owns the data the memory returns next cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rtag   <= 1'b0;
    end else begin
      r_rvalid <= o_mem_re;
      r_rtag   <= w_rd_win1;
    end
  end

  assign o_rvalid0 = r_rvalid & ~r_rtag;
  assign o_rvalid1 = r_rvalid & r_rtag;
  assign o_rdata   = i_mem_r_data;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: behavioural memory plus a reference arbitration model.
module tb_dmem_port_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic mem_we, mem_re;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic [DW-1:0] mem_w_data, mem_r_data;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_rvalid0(rvalid0), .o_rvalid1(rvalid1),
    .o_rdata(rdata),
    .o_mem_we(mem_we), .o_mem_w_addr(mem_w_addr), .o_mem_w_data(mem_w_data),
    .o_mem_re(mem_re), .o_mem_r_addr(mem_r_addr), .i_mem_r_data(mem_r_data)
  );

  // Behavioural dual-port memory: registered read with write-through, plus a preload path.
  logic [DW-1:0] mem [256];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_re) mem_r_data <= (mem_we && mem_w_addr == mem_r_addr) ? mem_w_data : mem[mem_r_addr];
    if (mem_we) mem[mem_w_addr] <= mem_w_data;
  end

  // Reference model state.
  logic [DW-1:0] m_mem [256];
`ifdef DMEM_ARB_PRIO_EN
  int m_wr_wait, m_rd_wait;
`else
  int m_wr_fav, m_rd_fav;
`endif
  bit p_rv0, p_rv1;
  logic [DW-1:0] p_rdata;
  bit c_wr0, c_wr1, c_rd0, c_rd1;
  int wr_win, rd_win;

  logic e_gnt0, e_gnt1, e_we, e_re, e_rv0, e_rv1;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_wdata, e_rdata;

  int checks = 0;
  int errors = 0;

  function automatic int pick(input bit c0, input bit c1, input int fav);
    if (c0 && c1) return fav;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
`ifdef DMEM_ARB_PRIO_EN
    m_wr_wait = 0;
    m_rd_wait = 0;
`else
    m_wr_fav = 0;
    m_rd_fav = 0;
`endif
    p_rv0 = 0;
    p_rv1 = 0;
  endtask

  // Drive one request pair at posedge+1, compute expectations, return at the negedge.
  task automatic apply(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int wf, rf;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    c_wr0 = r0 && w0 && !rst;
    c_wr1 = r1 && w1 && !rst;
    c_rd0 = r0 && !w0 && !rst;
    c_rd1 = r1 && !w1 && !rst;
`ifdef DMEM_ARB_PRIO_EN
    wf = (m_wr_wait == MW) ? 1 : 0;
    rf = (m_rd_wait == MW) ? 1 : 0;
`else
    wf = m_wr_fav;
    rf = m_rd_fav;
`endif
    wr_win  = pick(c_wr0, c_wr1, wf);
    rd_win  = pick(c_rd0, c_rd1, rf);
    e_gnt0  = (wr_win == 0) || (rd_win == 0);
    e_gnt1  = (wr_win == 1) || (rd_win == 1);
    e_we    = wr_win >= 0;
    e_re    = rd_win >= 0;
    e_waddr = (wr_win == 0) ? a0 : (wr_win == 1) ? a1 : '0;
    e_wdata = (wr_win == 0) ? d0 : (wr_win == 1) ? d1 : '0;
    e_raddr = (rd_win == 0) ? a0 : (rd_win == 1) ? a1 : '0;
    e_rv0   = p_rv0;
    e_rv1   = p_rv1;
    e_rdata = p_rdata;
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
`ifdef DMEM_ARB_PRIO_EN
    m_wr_wait = (c_wr1 && wr_win != 1) ? ((m_wr_wait < MW) ? m_wr_wait + 1 : MW) : 0;
    m_rd_wait = (c_rd1 && rd_win != 1) ? ((m_rd_wait < MW) ? m_rd_wait + 1 : MW) : 0;
`else
    if (c_wr0 && c_wr1) m_wr_fav = 1 - m_wr_fav;
    if (c_rd0 && c_rd1) m_rd_fav = 1 - m_rd_fav;
`endif
    p_rv0 = (rd_win == 0);
    p_rv1 = (rd_win == 1);
    if (rd_win >= 0) p_rdata = (wr_win >= 0 && e_waddr == e_raddr) ? e_wdata : m_mem[e_raddr];
    if (wr_win >= 0) m_mem[e_waddr] = e_wdata;
    #1;
  endtask

  task automatic idle();
    apply(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic pulse_reset();
    req0 = 0; req1 = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic preload();
    rst = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) begin
      pl_addr = AW'(i);
      pl_data = (i == 8'h10) ? 32'hDEAD_BEEF : (32'hA500_0000 ^ (i * 32'h0101_0101));
      m_mem[i] = pl_data;
      pl_en = 1;
      @(posedge clk); #1;
    end
    pl_en = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    apply(1, 0, 8'h01, '0, 1, 1, 8'h02, 32'h5);
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset gnt0: got %b expected 0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset gnt1: got %b expected 0", gnt1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset mem_re: got %b expected 0", mem_re); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL reset rvalid: got %b expected 00", {rvalid0, rvalid1}); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    // A completed read must have its rvalid killed immediately by reset.
    apply(1, 0, 8'h01, '0, 0, 0, '0, '0);
    advance();
    checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL async_pre rvalid0: got %b expected 1", rvalid0); end
    req0 = 0;
    rst = 1;
    #1;
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL async_rst rvalid0: got %b expected 0", rvalid0); end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_single_read();
    pulse_reset();
    apply(1, 0, 8'h10, '0, 0, 0, '0, '0);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL single gnt: got %b%b expected 10", gnt0, gnt1); end
    checks++; if (mem_re !== 1'b1 || mem_r_addr !== 8'h10) begin errors++; $display("FAIL single mem_re/addr: got %b/%h expected 1/10", mem_re, mem_r_addr); end
    advance();
    idle();
    checks++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin errors++; $display("FAIL single rvalid: got %b%b expected 10", rvalid0, rvalid1); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single rdata: got %h expected deadbeef", rdata); end
    advance();
  endtask

  task automatic test_write_through();
    apply(1, 1, 8'h20, 32'h1234_5678, 1, 0, 8'h20, '0);
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b1) begin errors++; $display("FAIL wthru gnt: got %b%b expected 11", gnt0, gnt1); end
    checks++; if (mem_we !== 1'b1 || mem_re !== 1'b1) begin errors++; $display("FAIL wthru we/re: got %b%b expected 11", mem_we, mem_re); end
    checks++; if (mem_w_data !== 32'h1234_5678) begin errors++; $display("FAIL wthru w_data: got %h expected 12345678", mem_w_data); end
    advance();
    idle();
    checks++; if (rvalid1 !== 1'b1 || rvalid0 !== 1'b0) begin errors++; $display("FAIL wthru rvalid: got %b%b expected 01", rvalid0, rvalid1); end
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL wthru rdata: got %h expected 12345678", rdata); end
    advance();
  endtask

  task automatic test_read_tie();
    pulse_reset();
    for (int i = 0; i < 11; i++) begin
      apply(1, 0, AW'(i), '0, 1, 0, AW'(i + 100), '0);
      checks++; if ({gnt0, gnt1} !== {e_gnt0, e_gnt1}) begin errors++; $display("FAIL tie[%0d] gnt: got %b%b expected %b%b", i, gnt0, gnt1, e_gnt0, e_gnt1); end
      checks++; if ({rvalid0, rvalid1} !== {e_rv0, e_rv1}) begin errors++; $display("FAIL tie[%0d] rvalid: got %b%b expected %b%b", i, rvalid0, rvalid1, e_rv0, e_rv1); end
      if (e_rv0 || e_rv1) begin
        checks++; if (rdata !== e_rdata) begin errors++; $display("FAIL tie[%0d] rdata: got %h expected %h", i, rdata, e_rdata); end
      end
      advance();
    end
  endtask

  task automatic test_write_solo();
    int pat [6] = '{3, 3, 2, 3, 3, 2};
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      apply(pat[i][0], 1, AW'(i + 40), DW'(i * 7), pat[i][1], 1, AW'(i + 50), DW'(i * 9));
      checks++; if ({gnt0, gnt1} !== {e_gnt0, e_gnt1}) begin errors++; $display("FAIL wsolo[%0d] gnt: got %b%b expected %b%b", i, gnt0, gnt1, e_gnt0, e_gnt1); end
      checks++; if (mem_w_addr !== e_waddr || mem_w_data !== e_wdata) begin errors++; $display("FAIL wsolo[%0d] waddr/data: got %h/%h expected %h/%h", i, mem_w_addr, mem_w_data, e_waddr, e_wdata); end
      advance();
    end
  endtask

  task automatic test_midflight_reset();
    pulse_reset();
    apply(0, 0, '0, '0, 1, 0, 8'h30, '0);
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL mid gnt1: got %b expected 1", gnt1); end
    #2;
    rst = 1;
    #1;
    checks++; if (gnt1 !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL mid forced gnt1/re: got %b/%b expected 0/0", gnt1, mem_re); end
    model_reset();
    @(posedge clk); #1;
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL mid rvalid1 in reset: got %b expected 0", rvalid1); end
    rst = 0;
    apply(1, 0, 8'h31, '0, 1, 0, 8'h32, '0);
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL mid rvalid1 after release: got %b expected 0", rvalid1); end
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid first tie: got %b%b expected 10", gnt0, gnt1); end
    advance();
    idle();
    checks++; if ({rvalid0, rvalid1} !== {e_rv0, e_rv1}) begin errors++; $display("FAIL mid rvalid: got %b%b expected %b%b", rvalid0, rvalid1, e_rv0, e_rv1); end
    advance();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom);
      checks++; if ({gnt0, gnt1} !== {e_gnt0, e_gnt1}) begin errors++; $display("FAIL rand[%0d] gnt: got %b%b expected %b%b", i, gnt0, gnt1, e_gnt0, e_gnt1); end
      checks++; if ({mem_we, mem_re} !== {e_we, e_re}) begin errors++; $display("FAIL rand[%0d] we/re: got %b%b expected %b%b", i, mem_we, mem_re, e_we, e_re); end
      checks++; if (mem_w_addr !== e_waddr || mem_w_data !== e_wdata) begin errors++; $display("FAIL rand[%0d] waddr/data: got %h/%h expected %h/%h", i, mem_w_addr, mem_w_data, e_waddr, e_wdata); end
      checks++; if (mem_r_addr !== e_raddr) begin errors++; $display("FAIL rand[%0d] raddr: got %h expected %h", i, mem_r_addr, e_raddr); end
      checks++; if ({rvalid0, rvalid1} !== {e_rv0, e_rv1}) begin errors++; $display("FAIL rand[%0d] rvalid: got %b%b expected %b%b", i, rvalid0, rvalid1, e_rv0, e_rv1); end
      if (e_rv0 || e_rv1) begin
        checks++; if (rdata !== e_rdata) begin errors++; $display("FAIL rand[%0d] rdata: got %h expected %h", i, rdata, e_rdata); end
      end
      advance();
    end
  endtask

  initial begin
    preload();
    test_reset();
    test_single_read();
    test_write_through();
    test_read_tie();
    test_write_solo();
    test_midflight_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
